// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response FIFO, redirect/drain FSM.
// Optional macro FETCH_BYPASS_EN forwards a response straight to instr_* when the FIFO is empty.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     rsp_pc_reg;      // address belonging to the next expected response
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_count_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [31:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic            rsp_ok;
    logic            credit_ok;
    logic            accept;
    logic            fifo_empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [CW-1:0]   out_after;
    logic [CW-1:0]   drop_next;
    logic [31:0]     redirect_aligned;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp_ok           = imem_rsp_valid && (outstanding_reg != '0);
    assign credit_ok        = ({1'b0, count_reg} + {1'b0, outstanding_reg}) < (CW + 1)'(DEPTH);
    assign imem_req_valid   = reset_n && (state_reg == RUN) && credit_ok && !redirect_valid;
    assign imem_req_addr    = fetch_pc_reg;
    assign accept           = imem_req_valid && imem_req_ready;
    assign fifo_empty       = (count_reg == '0);
    assign out_after        = outstanding_reg - CW'(rsp_ok);
    assign drop_next        = drop_count_reg - CW'(rsp_ok && (drop_count_reg != '0));
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_reg == RUN) && rsp_ok && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !redirect_valid && (!fifo_empty || bypass);
    assign pop         = instr_valid && instr_ready && !fifo_empty;
    assign push        = rsp_ok && (state_reg == RUN) && !redirect_valid && !(bypass && instr_ready);

    always_comb begin
        instr_data = 32'h0;
        instr_pc   = 32'h0;
        if (!fifo_empty) begin
            instr_data = mem_data[rd_ptr_reg];
            instr_pc   = mem_pc[rd_ptr_reg];
        end else if (bypass) begin
            instr_data = imem_rsp_data;
            instr_pc   = rsp_pc_reg;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_reg] <= imem_rsp_data;
            mem_pc[wr_ptr_reg]   <= rsp_pc_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_count_reg  <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            outstanding_reg <= out_after + CW'(accept);
            if (redirect_valid) begin
                fetch_pc_reg   <= redirect_aligned;
                rsp_pc_reg     <= redirect_aligned;
                count_reg      <= '0;
                rd_ptr_reg     <= '0;
                wr_ptr_reg     <= '0;
                drop_count_reg <= out_after;
                state_reg      <= ((state_reg == DRAIN) || (out_after != '0)) ? DRAIN : RUN;
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (state_reg == DRAIN) begin
                    drop_count_reg <= drop_next;
                    if (drop_next == '0) begin
                        state_reg <= RUN;
                    end
                end else begin
                    if (rsp_ok) begin
                        rsp_pc_reg <= rsp_pc_reg + 32'd4;
                    end
                    if (push) begin
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    end
                    if (pop) begin
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    end
                    count_reg <= count_reg + CW'(push) - CW'(pop);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2): a tiny in-order memory answers accepted requests a
// cycle later with data = ~addr; each step compares outputs against hand-computed values.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int          vec  = 0;
    int          errs = 0;
    bit          rsp_en;
    logic [31:0] mem_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] hs_pc[$];
    logic [31:0] hs_data[$];

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes before the edge, then present the next memory response.
    task automatic tick();
        @(negedge clk);
        if (reset_n && imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            acc_q.push_back(imem_req_addr);
        end
        if (instr_valid && instr_ready) begin
            hs_pc.push_back(instr_pc);
            hs_data.push_back(instr_data);
        end
        @(posedge clk);
        #1;
        if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mem_q.pop_front();
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_q.delete();
        acc_q.delete();
        hs_pc.delete();
        hs_data.delete();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rsp_en         = 1'b1;

        // Streaming with a 1-cycle memory.
        do_reset();
        chk("s1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s1_first_req_addr", imem_req_addr, 32'h0);
        tick();
        #1;
        chk("s1_instr_valid_latency", {31'b0, instr_valid}, BYP);
        tick();
        #1;
        chk("s1_instr_valid_2", {31'b0, instr_valid}, 32'd1);
        chk("s1_instr_pc_2", instr_pc, (BYP == 32'd1) ? 32'h4 : 32'h0);
        repeat (10) tick();
        chk("s1_acc_count_ge3", {31'b0, acc_q.size() >= 3}, 32'd1);
        chk("s1_acc0", acc_q[0], 32'h0);
        chk("s1_acc1", acc_q[1], 32'h4);
        chk("s1_acc2", acc_q[2], 32'h8);
        chk("s1_hs_count_ge3", {31'b0, hs_pc.size() >= 3}, 32'd1);
        chk("s1_hs_pc0", hs_pc[0], 32'h0);
        chk("s1_hs_pc1", hs_pc[1], 32'h4);
        chk("s1_hs_pc2", hs_pc[2], 32'h8);
        chk("s1_hs_data2", hs_data[2], 32'hFFFF_FFF7);

        // Credit limit with a stalled decoder, then redirect while the FIFO holds data.
        instr_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("s2_accepted", acc_q.size(), 32'd2);
        chk("s2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("s2_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("s2_instr_pc", instr_pc, 32'h0);
        chk("s2_instr_data", instr_data, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("s2_req_after_pop", {31'b0, imem_req_valid}, 32'd1);
        chk("s2_addr_after_pop", imem_req_addr, 32'h8);
        chk("s2_head_after_pop", instr_pc, 32'h4);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("s2_redir_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("s2_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("s2_flushed", {31'b0, instr_valid}, 32'd0);
        chk("s2_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s2_new_req_addr", imem_req_addr, 32'h40);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Redirect with two outstanding: both responses discarded, resume at 0x100.
        rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        chk("s3_credit_full", {31'b0, imem_req_valid}, 32'd0);
        acc_q.delete();
        hs_pc.delete();
        hs_data.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        chk("s3_redir_instr_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        tick();
        chk("s3_drain1_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s3_drain1_instr", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("s3_drain2_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s3_drain2_instr", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("s3_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s3_resume_addr", imem_req_addr, 32'h100);
        repeat (6) tick();
        chk("s3_first_acc", acc_q[0], 32'h100);
        chk("s3_first_hs_pc", hs_pc[0], 32'h100);
        chk("s3_first_hs_data", hs_data[0], 32'hFFFF_FEFF);

        // Second redirect during DRAIN overrides the first.
        rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        acc_q.delete();
        hs_pc.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        #1;
        chk("s4_drain_req", {31'b0, imem_req_valid}, 32'd0);
        repeat (3) tick();
        chk("s4_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s4_resume_addr", imem_req_addr, 32'h300);
        repeat (5) tick();
        chk("s4_first_acc", acc_q[0], 32'h300);
        chk("s4_first_hs_pc", hs_pc[0], 32'h300);

        // Address hold under backpressure and wrap at the top of the address space.
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        tick();
        chk("s5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s5_hold_addr", imem_req_addr, 32'h0);
        hs_pc.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        chk("s5_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("s5_top_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        #1;
        chk("s5_wrap_addr", imem_req_addr, 32'h0);
        repeat (4) tick();
        chk("s5_top_hs_pc", hs_pc[0], 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
